// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Shared definitions for the SPI LCD receiver: panel command opcodes,
//   decoder state encoding, parameter-target selector and default panel size.
package lcd_pkg;

   localparam int LCD_DEF_WIDTH  = 240;
   localparam int LCD_DEF_HEIGHT = 135;

   localparam logic [7:0] CMD_SLPIN   = 8'h10;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_RASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam logic [7:0] CMD_MADCTL  = 8'h36;
   localparam logic [7:0] CMD_COLMOD  = 8'h3A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PARAM,
      ST_DISCARD,
      ST_PIX_A,
      ST_PIX_B
   } dec_state_t;

   typedef enum logic [1:0] {
      PSEL_CASET,
      PSEL_RASET,
      PSEL_COLMOD,
      PSEL_MADCTL
   } param_sel_t;

   // Effective window end: a start beyond the end collapses the window
   // to a single column/row at the start coordinate.
   function automatic logic [15:0] win_end(input logic [15:0] s, input logic [15:0] e);
      return (s > e) ? s : e;
   endfunction

endpackage

// File: rtl/spi_slave_byte.sv
// spi_slave_byte
//   SPI mode-0 byte receiver running entirely in the clk domain.
//   All SPI pins are brought in through 2-flop synchronizers; SCK edges are
//   detected on the synchronized copy, so SCK must be no faster than clk/8.
// Ports
//   clk, rst_n           system clock, async active-low reset
//   i_spi_cs             chip select, active-low (clears the bit counter)
//   i_spi_sck            serial clock, MOSI sampled on rise
//   i_spi_mosi           serial data, MSB first
//   i_spi_dc             data/command flag, captured with the 8th bit
//   o_byte_valid         one-clk strobe, one clk after the 8th SCK rise
//   o_byte, o_byte_dc    received byte and its D/C flag
module spi_slave_byte #(
   parameter int CLK_FRE = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_spi_cs,
   input  logic       i_spi_sck,
   input  logic       i_spi_mosi,
   input  logic       i_spi_dc,
   output logic       o_byte_valid,
   output logic [7:0] o_byte,
   output logic       o_byte_dc
);

   // Minimum clk cycles between any two SCK edges at the clk/8 limit.
   localparam int SCK_MIN_GAP = 4;

   logic [1:0] r_cs_sync;
   logic [1:0] r_sck_sync;
   logic [1:0] r_mosi_sync;
   logic [1:0] r_dc_sync;
   logic       r_sck_d;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_shift;
   logic [7:0] r_byte;
   logic       r_valid;
   logic       r_dc;
   logic [1:0] r_gap_tmr;

   logic w_cs;
   logic w_sck;
   logic w_mosi;
   logic w_dc;
   logic w_sck_rise;
   logic w_sck_edge;

   assign w_cs       = r_cs_sync[1];
   assign w_sck      = r_sck_sync[1];
   assign w_mosi     = r_mosi_sync[1];
   assign w_dc       = r_dc_sync[1];
   assign w_sck_rise = w_sck & ~r_sck_d;
   assign w_sck_edge = w_sck ^ r_sck_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_sync   <= '0;
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_dc_sync   <= '0;
         r_sck_d     <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[0], i_spi_cs};
         r_sck_sync  <= {r_sck_sync[0], i_spi_sck};
         r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
         r_dc_sync   <= {r_dc_sync[0], i_spi_dc};
         r_sck_d     <= w_sck;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_byte    <= '0;
         r_valid   <= 1'b0;
         r_dc      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_cs) begin
            r_bit_cnt <= '0;
         end else if (w_sck_rise) begin
            r_shift   <= {r_shift[5:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_byte  <= {r_shift, w_mosi};
               r_dc    <= w_dc;
               r_valid <= 1'b1;
            end
         end
      end
   end

   // SCK rate monitor: down-counter reloaded on every SCK edge; an edge
   // arriving before terminal count means SCK exceeds clk/8.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap_tmr <= '0;
      end else if (w_sck_edge) begin
         assert (w_cs || (r_gap_tmr == '0))
            else $error("spi_slave_byte: SCK faster than %0d kHz", (CLK_FRE * 1000) / 8);
         r_gap_tmr <= 2'(SCK_MIN_GAP - 1);
      end else if (r_gap_tmr != '0) begin
         r_gap_tmr <= r_gap_tmr - 2'd1;
      end
   end

   assign o_byte_valid = r_valid;
   assign o_byte       = r_byte;
   assign o_byte_dc    = r_dc;

endmodule

// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx
//   Receives an ST7789-style SPI command stream and turns RAMWR pixel data
//   into framebuffer writes inside the CASET/RASET window.
// Ports
//   clk, rst_n                      system clock, async active-low reset
//   spi_cs, spi_dc, spi_sck, spi_mosi   SPI slave inputs (async to clk)
//   spi_miso                        tied low, reads unsupported
//   fb_we, fb_addr, fb_wdata        framebuffer write port (y*W + x, RGB565)
//   frame_done                      pulse with the write of window pixel (xe,ye)
//   sleep_out, disp_on              panel status flags
//   colmod, madctl                  last written register values
//
// Decoder states
//   state      | meaning
//   ST_IDLE    | no active sequence, data bytes ignored
//   ST_PARAM   | collecting parameter bytes for CASET/RASET/COLMOD/MADCTL
//   ST_DISCARD | unknown command or surplus parameters, data ignored
//   ST_PIX_A   | waiting for first byte of a pixel
//   ST_PIX_B   | first byte held, second byte completes the pixel
module spi_lcd_rx
   import lcd_pkg::*;
#(
   parameter int CLK_FRE        = 27,
   parameter int DISPLAY_WIDTH  = LCD_DEF_WIDTH,
   parameter int DISPLAY_HEIGHT = LCD_DEF_HEIGHT,
   parameter int PIX_LSB_FIRST  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_cs,
   input  logic        spi_dc,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        fb_we,
   output logic [14:0] fb_addr,
   output logic [15:0] fb_wdata,
   output logic        sleep_out,
   output logic        disp_on,
   output logic [7:0]  colmod,
   output logic [7:0]  madctl,
   output logic        frame_done
);

   logic       w_byte_valid;
   logic [7:0] w_byte;
   logic       w_byte_dc;

   spi_slave_byte #(
      .CLK_FRE (CLK_FRE)
   ) u_spi_slave_byte (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_spi_cs     (spi_cs),
      .i_spi_sck    (spi_sck),
      .i_spi_mosi   (spi_mosi),
      .i_spi_dc     (spi_dc),
      .o_byte_valid (w_byte_valid),
      .o_byte       (w_byte),
      .o_byte_dc    (w_byte_dc)
   );

   dec_state_t  r_state;
   dec_state_t  w_state_nxt;
   param_sel_t  r_param_sel;
   logic [1:0]  r_param_cnt;
   logic [23:0] r_param_buf;
   logic [15:0] r_xs;
   logic [15:0] r_xe;
   logic [15:0] r_ys;
   logic [15:0] r_ye;
   logic [15:0] r_x;
   logic [15:0] r_y;
   logic [7:0]  r_pix_first;
   logic        r_fb_we;
   logic [14:0] r_fb_addr;
   logic [15:0] r_fb_wdata;
   logic        r_frame_done;
   logic        r_sleep_out;
   logic        r_disp_on;
   logic [7:0]  r_colmod;
   logic [7:0]  r_madctl;

   logic        w_cmd;
   logic        w_data;
   logic [15:0] w_xe_eff;
   logic [15:0] w_ye_eff;
   logic        w_x_last;
   logic        w_y_last;
   logic        w_in_range;
   logic [15:0] w_pixel;
   logic [14:0] w_addr;

   assign w_cmd      = w_byte_valid & ~w_byte_dc;
   assign w_data     = w_byte_valid & w_byte_dc;
   assign w_xe_eff   = win_end(r_xs, r_xe);
   assign w_ye_eff   = win_end(r_ys, r_ye);
   // >= rather than == so a position left outside the window still wraps.
   assign w_x_last   = (r_x >= w_xe_eff);
   assign w_y_last   = (r_y >= w_ye_eff);
   assign w_in_range = (r_x < 16'(DISPLAY_WIDTH)) && (r_y < 16'(DISPLAY_HEIGHT));
   assign w_pixel    = (PIX_LSB_FIRST != 0) ? {w_byte, r_pix_first} : {r_pix_first, w_byte};
   assign w_addr     = r_y[14:0] * 15'(DISPLAY_WIDTH) + r_x[14:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_cmd) begin
         case (w_byte)
            CMD_SLPIN, CMD_SLPOUT, CMD_DISPOFF, CMD_DISPON: w_state_nxt = ST_IDLE;
            CMD_CASET, CMD_RASET, CMD_COLMOD, CMD_MADCTL:   w_state_nxt = ST_PARAM;
            CMD_RAMWR:                                       w_state_nxt = ST_PIX_A;
            default:                                         w_state_nxt = ST_DISCARD;
         endcase
      end else if (w_data) begin
         case (r_state)
            ST_PARAM: if (r_param_cnt == 2'd0) w_state_nxt = ST_DISCARD;
            ST_PIX_A: w_state_nxt = ST_PIX_B;
            ST_PIX_B: w_state_nxt = ST_PIX_A;
            default:  w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_param_sel  <= PSEL_CASET;
         r_param_cnt  <= '0;
         r_param_buf  <= '0;
         r_xs         <= '0;
         r_xe         <= 16'(DISPLAY_WIDTH - 1);
         r_ys         <= '0;
         r_ye         <= 16'(DISPLAY_HEIGHT - 1);
         r_x          <= '0;
         r_y          <= '0;
         r_pix_first  <= '0;
         r_fb_we      <= 1'b0;
         r_fb_addr    <= '0;
         r_fb_wdata   <= '0;
         r_frame_done <= 1'b0;
         r_sleep_out  <= 1'b0;
         r_disp_on    <= 1'b0;
         r_colmod     <= '0;
         r_madctl     <= '0;
      end else begin
         r_fb_we      <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_cmd) begin
            case (w_byte)
               CMD_SLPOUT:  r_sleep_out <= 1'b1;
               CMD_SLPIN:   r_sleep_out <= 1'b0;
               CMD_DISPON:  r_disp_on   <= 1'b1;
               CMD_DISPOFF: r_disp_on   <= 1'b0;
               CMD_CASET: begin
                  r_param_sel <= PSEL_CASET;
                  r_param_cnt <= 2'd3;
               end
               CMD_RASET: begin
                  r_param_sel <= PSEL_RASET;
                  r_param_cnt <= 2'd3;
               end
               CMD_COLMOD: begin
                  r_param_sel <= PSEL_COLMOD;
                  r_param_cnt <= 2'd0;
               end
               CMD_MADCTL: begin
                  r_param_sel <= PSEL_MADCTL;
                  r_param_cnt <= 2'd0;
               end
               CMD_RAMWR: begin
                  r_x <= r_xs;
                  r_y <= r_ys;
               end
               default: ;
            endcase
         end else if (w_data) begin
            case (r_state)
               ST_PARAM: begin
                  if (r_param_cnt == 2'd0) begin
                     case (r_param_sel)
                        PSEL_CASET: begin
                           r_xs <= r_param_buf[23:8];
                           r_xe <= {r_param_buf[7:0], w_byte};
                        end
                        PSEL_RASET: begin
                           r_ys <= r_param_buf[23:8];
                           r_ye <= {r_param_buf[7:0], w_byte};
                        end
                        PSEL_COLMOD: r_colmod <= w_byte;
                        PSEL_MADCTL: r_madctl <= w_byte;
                        default: ;
                     endcase
                  end else begin
                     r_param_buf <= {r_param_buf[15:0], w_byte};
                     r_param_cnt <= r_param_cnt - 2'd1;
                  end
               end
               ST_PIX_A: r_pix_first <= w_byte;
               ST_PIX_B: begin
                  r_fb_we      <= w_in_range;
                  r_fb_addr    <= w_addr;
                  r_fb_wdata   <= w_pixel;
                  r_frame_done <= w_x_last & w_y_last;
                  if (w_x_last) begin
                     r_x <= r_xs;
                     r_y <= w_y_last ? r_ys : (r_y + 16'd1);
                  end else begin
                     r_x <= r_x + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign spi_miso   = 1'b0;
   assign fb_we      = r_fb_we;
   assign fb_addr    = r_fb_addr;
   assign fb_wdata   = r_fb_wdata;
   assign frame_done = r_frame_done;
   assign sleep_out  = r_sleep_out;
   assign disp_on    = r_disp_on;
   assign colmod     = r_colmod;
   assign madctl     = r_madctl;

endmodule
